regfile_writeback_queue: RTL and testbench

Writer-side front end for the 32×32 register file: collects write-back results from the ALU and the load/store unit, buffers them in a small in-order queue, and drains exactly one write per cycle onto the register file's regWrite/writeRegister/writeData port. Sits between the execute/memory stages and the register file. Also provides a two-port bypass lookup so decode can see values still pending in the queue.

---
 rtl/regfile_writeback_queue.sv | 141 ++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue in front of the 32x32 register file: merges load and ALU results,
// retires one write per cycle and exposes pending values to decode through a bypass lookup.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        stall,
  output logic        overflow,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  input  logic [4:0]  fwd_reg1,
  input  logic [4:0]  fwd_reg2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } fwd_t;

  logic [DEPTH-1:0][4:0]  rd_mem_q;
  logic [DEPTH-1:0][31:0] data_mem_q;

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] alu_idx;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic          overflow_q, overflow_d;
  logic          regwrite_q;
  logic [4:0]    wreg_q;
  logic [31:0]   wdata_q;

  logic pop, mem_want, alu_want, mem_acc, alu_acc, drop;
  fwd_t fwd1, fwd2;

  // Space accounting: the head popped at this edge already frees its slot for the new entries.
  always_comb begin
    pop      = (count_q != '0);
    free     = DepthC - count_q + CW'(pop);
    mem_want = mem_valid && (mem_rd != 5'd0);
    alu_want = alu_valid && (alu_rd != 5'd0);
    mem_acc  = mem_want && (free != '0);
    alu_acc  = alu_want && (mem_acc ? (free > CW'(1)) : (free != '0));
    drop     = (mem_want && !mem_acc) || (alu_want && !alu_acc);

    alu_idx    = mem_acc ? (wptr_q + AW'(1)) : wptr_q;
    wptr_d     = wptr_q + AW'(mem_acc) + AW'(alu_acc);
    rptr_d     = rptr_q + AW'(pop);
    count_d    = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    overflow_d = overflow_q | drop;
  end

  // Payload storage needs no reset: only slots inside [rptr, rptr+count) are ever observed.
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      rd_mem_q[wptr_q]   <= mem_rd;
      data_mem_q[wptr_q] <= mem_data;
    end
    if (alu_acc) begin
      rd_mem_q[alu_idx]   <= alu_rd;
      data_mem_q[alu_idx] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      regwrite_q <= pop;
      if (pop) begin
        wreg_q  <= rd_mem_q[rptr_q];
        wdata_q <= data_mem_q[rptr_q];
      end
    end
  end

  // Scan oldest to youngest so the newest matching entry overrides; the output register is oldest.
  function automatic fwd_t lookup(input logic [4:0] r);
    fwd_t          res;
    logic [AW-1:0] idx;
    res = '0;
    if (r != 5'd0) begin
      if (regwrite_q && (wreg_q == r)) begin
        res.hit  = 1'b1;
        res.data = wdata_q;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rptr_q + AW'(i);
        if ((CW'(i) < count_q) && (rd_mem_q[idx] == r)) begin
          res.hit  = 1'b1;
          res.data = data_mem_q[idx];
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    fwd1 = lookup(fwd_reg1);
    fwd2 = lookup(fwd_reg2);
  end

  assign fwd_hit1      = fwd1.hit;
  assign fwd_data1     = fwd1.data;
  assign fwd_hit2      = fwd2.hit;
  assign fwd_data2     = fwd2.data;
  assign stall         = (DepthC - count_q) < CW'(2);
  assign overflow      = overflow_q;
  assign regWrite      = regwrite_q;
  assign writeRegister = wreg_q;
  assign writeData     = wdata_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DepthC);

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomised scoreboard bench for regfile_writeback_queue against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst_n;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd, fwd_reg1, fwd_reg2;
  logic [31:0] mem_data, alu_data;
  logic        stall, overflow, regWrite, fwd_hit1, fwd_hit2;
  logic [4:0]  writeRegister;
  logic [31:0] writeData, fwd_data1, fwd_data2;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .stall(stall), .overflow(overflow),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        expq[$];
  bit          m_out_v;
  logic [4:0]  m_out_rd;
  logic [31:0] m_out_data;
  bit          m_ovf;
  int          tests = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    m_out_v    = 1'b0;
    m_out_rd   = 5'd0;
    m_out_data = 32'd0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_offer(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ent_t e;
    if (v && rd != 5'd0) begin
      if (mq.size() < DEPTH) begin
        e.rd = rd;
        e.data = d;
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // One clock edge: retire the oldest pending write, then admit mem before alu.
  task automatic model_step();
    ent_t e;
    if (mq.size() != 0) begin
      e = mq.pop_front();
      expq.push_back(e);
      m_out_v    = 1'b1;
      m_out_rd   = e.rd;
      m_out_data = e.data;
    end else begin
      m_out_v = 1'b0;
    end
    model_offer(mem_valid, mem_rd, mem_data);
    model_offer(alu_valid, alu_rd, alu_data);
  endtask

  task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (r != 5'd0) begin
      if (m_out_v && m_out_rd == r) begin
        hit = 1'b1;
        d   = m_out_data;
      end
      foreach (mq[i]) begin
        if (mq[i].rd == r) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
    end
  endtask

  task automatic check_comb();
    logic        h;
    logic [31:0] d;
    check("regWrite", regWrite, m_out_v);
    check("writeRegister", writeRegister, m_out_rd);
    check("writeData", writeData, m_out_data);
    check("stall", stall, (DEPTH - mq.size()) < 2);
    check("overflow", overflow, m_ovf);
    model_fwd(fwd_reg1, h, d);
    check("fwd_hit1", fwd_hit1, h);
    check("fwd_data1", fwd_data1, d);
    model_fwd(fwd_reg2, h, d);
    check("fwd_hit2", fwd_hit2, h);
    check("fwd_data2", fwd_data2, d);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] f1, input logic [4:0] f2);
    fwd_reg1 = f1;
    fwd_reg2 = f2;
    #1;
    check_comb();
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Monitor: every retired write must match the oldest expected write.
  always begin
    ent_t e;
    @(posedge clk);
    #1;
    if (rst_n && regWrite) begin
      tests++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got write r%0d=0x%08h, required no write", writeRegister,
                 writeData);
      end else begin
        e = expq.pop_front();
        if (writeRegister !== e.rd || writeData !== e.data) begin
          failures++;
          $display("FAIL sb_write: got r%0d=0x%08h, required r%0d=0x%08h", writeRegister,
                   writeData, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    logic mv, av;
    rst_n = 1'b0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    fwd_reg1 = 0; fwd_reg2 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_regWrite", regWrite, 0);
    check("rst_writeRegister", writeRegister, 0);
    check("rst_writeData", writeData, 0);
    check("rst_stall", stall, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(3);

    // Single ALU write, visible for one cycle only.
    cycle(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    idle(3);

    // Dual issue to r3: mem older, alu younger wins the bypass.
    cycle(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 5'd3, 5'd0);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd3);
    idle(3);

    // x0 result is discarded without overflow.
    cycle(1, 5'd7, 32'h66, 1, 5'd0, 32'h55, 5'd0, 5'd7);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd7);
    idle(3);

    // Saturate with two results per cycle, ignoring stall.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 5'(8 + (2 * i) % 16), 32'hA000 + 32'(i), 1, 5'(9 + (2 * i) % 16),
            32'hB000 + 32'(i), 5'(8 + i), 5'(9 + i));
    end
    idle(6);

    // Mostly stall-respecting random traffic over a small register window for frequent hits.
    for (int i = 0; i < 400; i++) begin
      mv = 1'($urandom_range(0, 1));
      av = 1'($urandom_range(0, 1));
      if (stall && $urandom_range(0, 3) != 0) begin
        mv = 0;
        av = 0;
      end
      cycle(mv, 5'($urandom_range(0, 7)), $urandom, av, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);

    // Reset with three entries pending.
    cycle(1, 5'd9, 32'hA1, 1, 5'd10, 32'hA2, 5'd0, 5'd0);
    cycle(1, 5'd11, 32'hA3, 1, 5'd12, 32'hA4, 5'd12, 5'd11);
    mem_valid = 0;
    alu_valid = 0;
    fwd_reg1  = 5'd12;
    fwd_reg2  = 5'd11;
    #1;
    check_comb();
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regWrite", regWrite, 0);
    check("mid_rst_fwd_hit1", fwd_hit1, 0);
    check("mid_rst_fwd_hit2", fwd_hit2, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_writeData", writeData, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    idle(5);

    check("drain_empty", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
